// File: rtl/sc_regbank_pkg.sv
// sc_regbank_pkg: clear-FSM state encoding and fixed register indices shared by the bank
package sc_regbank_pkg;
  localparam int STATE_W = 1;
  typedef enum logic [STATE_W-1:0] {IDLE = 1'b0, CLEAR = 1'b1} state_e;
  localparam int ZERO_IDX = 0;
  localparam int R1_IDX = 1;
endpackage

// File: rtl/sc_regbank_general_if.sv
// sc_regbank_general_if: write/read control, register-1 output and Busy of the register bank
// master drives write strobe/addr/data, read enables/addrs and clear; slave returns DataBUS_Out and Busy_OutHigh
interface sc_regbank_general_if #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int ADDRWIDTH = 4
);
  logic                     Write_InHigh;
  logic [ADDRWIDTH-1:0]     WriteAddr;
  logic [DATAWIDTH_BUS-1:0] DataBUS_In;
  logic                     ENABLE_BUS_A;
  logic                     ENABLE_BUS_B;
  logic [ADDRWIDTH-1:0]     AddrA;
  logic [ADDRWIDTH-1:0]     AddrB;
  logic                     Clear_InHigh;
  logic [DATAWIDTH_BUS-1:0] DataBUS_Out;
  logic                     Busy_OutHigh;
  modport master(
    output Write_InHigh, WriteAddr, DataBUS_In, ENABLE_BUS_A, ENABLE_BUS_B, AddrA, AddrB, Clear_InHigh,
    input  DataBUS_Out, Busy_OutHigh
  );
  modport slave(
    input  Write_InHigh, WriteAddr, DataBUS_In, ENABLE_BUS_A, ENABLE_BUS_B, AddrA, AddrB, Clear_InHigh,
    output DataBUS_Out, Busy_OutHigh
  );
endinterface

// File: rtl/sc_regbank_clear_fsm.sv
// sc_regbank_clear_fsm: sequences a bank clear, one register per falling edge
// ports: clk, rst_n (sync, active-low), clear_i request; busy_o, clr_we_o/clr_addr_o register-clear strobe and index
module sc_regbank_clear_fsm
  import sc_regbank_pkg::*;
#(
  parameter int ADDRWIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 clr_we_o,
  output logic [ADDRWIDTH-1:0] clr_addr_o
);
  state_e               state_q, state_d;
  logic [ADDRWIDTH-1:0] cnt_q, cnt_d;
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // terminal count is the all-ones index, so the walk ends after the last register without wrapping
  always_comb begin
    state_d = (state_q == IDLE) ? (clear_i ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d   = (state_q == CLEAR && !(&cnt_q)) ? cnt_q + 1'b1 : '0;
  end
  assign busy_o     = (state_q == CLEAR);
  assign clr_we_o   = busy_o;
  assign clr_addr_o = cnt_q;
endmodule

// File: rtl/sc_regbank_general.sv
// sc_regbank_general: general register bank with one write port, two tri-state read buses and register-1 output
// ports: SC_RegBANK_CLOCK_50 (state on falling edge), SC_RegBANK_Reset_InLow (sync, active-low),
//        bus (write/read/clear controls, DataBUS_Out, Busy_OutHigh), SC_RegBANK_DataBUS_Out_A/_B (Z when disabled)
module sc_regbank_general
  import sc_regbank_pkg::*;
#(
  parameter int                         DATAWIDTH_BUS    = 32,
  parameter int                         ADDRWIDTH        = 4,
  parameter logic [DATAWIDTH_BUS-1:0]   DATA_REGGEN_INIT = '0,
  parameter bit                         ZERO_REG0        = 1'b1,
  parameter bit                         BYPASS           = 1'b1
) (
  input  logic                     SC_RegBANK_CLOCK_50,
  input  logic                     SC_RegBANK_Reset_InLow,
  sc_regbank_general_if.slave      bus,
  output wire [DATAWIDTH_BUS-1:0]  SC_RegBANK_DataBUS_Out_A,
  output wire [DATAWIDTH_BUS-1:0]  SC_RegBANK_DataBUS_Out_B
);
  localparam int DEPTH = 2 ** ADDRWIDTH;
  logic [DATAWIDTH_BUS-1:0] bank_q [DEPTH];
  logic                     busy, clr_we, wr_ok;
  logic [ADDRWIDTH-1:0]     clr_addr, waddr;
  logic [DATAWIDTH_BUS-1:0] din;
  sc_regbank_clear_fsm #(.ADDRWIDTH(ADDRWIDTH)) u_clear (
    .clk        (SC_RegBANK_CLOCK_50),
    .rst_n      (SC_RegBANK_Reset_InLow),
    .clear_i    (bus.Clear_InHigh),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );
  function automatic logic is_zero(input logic [ADDRWIDTH-1:0] a);
    return ZERO_REG0 && a == ADDRWIDTH'(ZERO_IDX);
  endfunction
  function automatic logic [DATAWIDTH_BUS-1:0] init_of(input logic [ADDRWIDTH-1:0] a);
    return is_zero(a) ? '0 : DATA_REGGEN_INIT;
  endfunction
  // bypass only forwards a write that will really land, so clear/busy/zero-register cases read stored contents
  function automatic logic [DATAWIDTH_BUS-1:0] rd(input logic [ADDRWIDTH-1:0] a);
    return is_zero(a) ? '0 : (BYPASS && wr_ok && a == waddr) ? din : bank_q[a];
  endfunction
  assign waddr = bus.WriteAddr;
  assign din   = bus.DataBUS_In;
  // a clear request in IDLE takes priority over a simultaneous write
  assign wr_ok = bus.Write_InHigh && !busy && !bus.Clear_InHigh && !is_zero(waddr);
  always_ff @(negedge SC_RegBANK_CLOCK_50) begin
    if (!SC_RegBANK_Reset_InLow)
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= init_of(ADDRWIDTH'(i));
    else if (clr_we)
      bank_q[clr_addr] <= init_of(clr_addr);
    else if (wr_ok)
      bank_q[waddr] <= din;
  end
  assign SC_RegBANK_DataBUS_Out_A = bus.ENABLE_BUS_A ? rd(bus.AddrA) : 'z;
  assign SC_RegBANK_DataBUS_Out_B = bus.ENABLE_BUS_B ? rd(bus.AddrB) : 'z;
  assign bus.DataBUS_Out  = rd(ADDRWIDTH'(R1_IDX));
  assign bus.Busy_OutHigh = busy;
endmodule

// File: tb/tb_sc_regbank_general.sv
// tb_sc_regbank_general: bank with zero-reg+bypass beside one without, checked against an array model and literals
module tb_sc_regbank_general;
  localparam logic [31:0] INIT = 32'h0000_C1EA;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  sc_regbank_general_if #(.DATAWIDTH_BUS(32), .ADDRWIDTH(4)) b1 ();
  sc_regbank_general_if #(.DATAWIDTH_BUS(32), .ADDRWIDTH(4)) b2 ();
  wire [31:0] oa1, ob1, oa2, ob2;
  sc_regbank_general #(.DATA_REGGEN_INIT(INIT)) dut1 (
    .SC_RegBANK_CLOCK_50(clk), .SC_RegBANK_Reset_InLow(rstn), .bus(b1),
    .SC_RegBANK_DataBUS_Out_A(oa1), .SC_RegBANK_DataBUS_Out_B(ob1)
  );
  sc_regbank_general #(.DATA_REGGEN_INIT(INIT), .ZERO_REG0(1'b0), .BYPASS(1'b0)) dut2 (
    .SC_RegBANK_CLOCK_50(clk), .SC_RegBANK_Reset_InLow(rstn), .bus(b2),
    .SC_RegBANK_DataBUS_Out_A(oa2), .SC_RegBANK_DataBUS_Out_B(ob2)
  );
  assign b2.Write_InHigh = b1.Write_InHigh;
  assign b2.WriteAddr    = b1.WriteAddr;
  assign b2.DataBUS_In   = b1.DataBUS_In;
  assign b2.ENABLE_BUS_A = b1.ENABLE_BUS_A;
  assign b2.ENABLE_BUS_B = b1.ENABLE_BUS_B;
  assign b2.AddrA        = b1.AddrA;
  assign b2.AddrB        = b1.AddrB;
  assign b2.Clear_InHigh = b1.Clear_InHigh;
  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  logic [31:0] m1 [16];
  logic [31:0] m2 [16];
  bit m_busy = 1'b0;
  int k = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  task automatic chkz(input string nm, input logic [31:0] act);
    tests++;
    if (!(act === 'z || act === '0)) begin
      fails++;
      $display("FAIL %s actual=%h expected=Z t=%0t", nm, act, $time);
    end
  endtask
  // model: dut1 reads 0 at address 0 and forwards an accepted write; dut2 is a plain array
  function automatic logic [31:0] e1(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (!m_busy && b1.Write_InHigh && !b1.Clear_InHigh && a == b1.WriteAddr) return b1.DataBUS_In;
    return m1[a];
  endfunction
  always @(negedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) begin
        m1[i] <= (i == 0) ? 32'h0 : INIT;
        m2[i] <= INIT;
      end
      m_busy <= 1'b0;
      k <= 0;
    end else if (m_busy) begin
      m1[k] <= (k == 0) ? 32'h0 : INIT;
      m2[k] <= INIT;
      m_busy <= (k != 15);
      k <= k + 1;
    end else if (b1.Clear_InHigh) begin
      m_busy <= 1'b1;
      k <= 0;
    end else if (b1.Write_InHigh) begin
      m2[b1.WriteAddr] <= b1.DataBUS_In;
      if (b1.WriteAddr != 4'd0) m1[b1.WriteAddr] <= b1.DataBUS_In;
    end
  end
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      if (b1.ENABLE_BUS_A) begin
        chk("cyc_a1", oa1, e1(b1.AddrA));
        chk("cyc_a2", oa2, m2[b1.AddrA]);
      end else begin
        chkz("cyc_a1_z", oa1);
        chkz("cyc_a2_z", oa2);
      end
      if (b1.ENABLE_BUS_B) begin
        chk("cyc_b1", ob1, e1(b1.AddrB));
        chk("cyc_b2", ob2, m2[b1.AddrB]);
      end else begin
        chkz("cyc_b1_z", ob1);
        chkz("cyc_b2_z", ob2);
      end
      chk("cyc_dout1", b1.DataBUS_Out, e1(4'd1));
      chk("cyc_dout2", b2.DataBUS_Out, m2[1]);
      chk("cyc_busy1", {31'b0, b1.Busy_OutHigh}, {31'b0, m_busy});
      chk("cyc_busy2", {31'b0, b2.Busy_OutHigh}, {31'b0, m_busy});
    end
  end
  task automatic step();
    @(posedge clk);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step();
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = a;
    b1.DataBUS_In = d;
    step();
    b1.Write_InHigh = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #3;
      if (!b1.Busy_OutHigh) break;
      n++;
      step();
      b1.Write_InHigh = 1'b0;
    end
  endtask
  int n;
  initial begin
    b1.Write_InHigh = 1'b0;
    b1.WriteAddr = '0;
    b1.DataBUS_In = '0;
    b1.ENABLE_BUS_A = 1'b1;
    b1.ENABLE_BUS_B = 1'b1;
    b1.AddrA = 4'd3;
    b1.AddrB = 4'd3;
    b1.Clear_InHigh = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk_en = 1'b1;
    #3;
    chk("rst_dout", b1.DataBUS_Out, INIT);
    chk("rst_busy", {31'b0, b1.Busy_OutHigh}, 32'h0);
    chk("rst_r3", oa1, INIT);
    wr(4'd3, 32'hA5A5_0001);
    #3;
    chk("w3_a", oa1, 32'hA5A5_0001);
    chk("w3_b", ob1, 32'hA5A5_0001);
    step();
    b1.ENABLE_BUS_A = 1'b0;
    b1.ENABLE_BUS_B = 1'b0;
    #3;
    chkz("dis_a", oa1);
    chkz("dis_b", ob1);
    step();
    b1.ENABLE_BUS_A = 1'b1;
    b1.ENABLE_BUS_B = 1'b1;
    b1.AddrA = 4'd0;
    b1.AddrB = 4'd1;
    wr(4'd0, 32'hFFFF_FFFF);
    #3;
    chk("zero_r0", oa1, 32'h0);
    chk("plain_r0", oa2, 32'hFFFF_FFFF);
    wr(4'd1, 32'h0000_1234);
    #3;
    chk("r1_dout", b1.DataBUS_Out, 32'h0000_1234);
    chk("r1_dout2", b2.DataBUS_Out, 32'h0000_1234);
    step();
    b1.AddrA = 4'd5;
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd5;
    b1.DataBUS_In = 32'hDEAD_BEEF;
    #3;
    chk("byp_a", oa1, 32'hDEAD_BEEF);
    chk("nobyp_a", oa2, INIT);
    step();
    b1.Write_InHigh = 1'b0;
    #3;
    chk("nobyp_after", oa2, 32'hDEAD_BEEF);
    step();
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd1;
    b1.DataBUS_In = 32'h0000_5151;
    #3;
    chk("byp_dout", b1.DataBUS_Out, 32'h0000_5151);
    chk("nobyp_dout", b2.DataBUS_Out, 32'h0000_1234);
    step();
    b1.Write_InHigh = 1'b0;
    for (int i = 1; i < 16; i++) wr(4'(i), 32'(i));
    b1.AddrA = 4'd10;
    b1.AddrB = 4'd15;
    step();
    b1.Clear_InHigh = 1'b1;
    step();
    b1.Clear_InHigh = 1'b0;
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd7;
    b1.DataBUS_In = 32'h77;
    wait_idle(n);
    chk("busy_len", n, 32'd16);
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd7;
    b1.DataBUS_In = 32'h99;
    b1.AddrA = 4'd7;
    step();
    b1.Write_InHigh = 1'b0;
    #3;
    chk("post_clr_w7", oa2, 32'h99);
    chk("clr_r15", ob1, INIT);
    wr(4'd2, 32'h22);
    b1.AddrA = 4'd2;
    step();
    b1.Clear_InHigh = 1'b1;
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd2;
    b1.DataBUS_In = 32'h55;
    step();
    b1.Clear_InHigh = 1'b0;
    b1.Write_InHigh = 1'b0;
    #3;
    chk("cw_pre", oa2, 32'h22);
    wait_idle(n);
    chk("cw_busy_len", n, 32'd16);
    chk("cw_r2", oa2, INIT);
    wr(4'd9, 32'h99);
    b1.AddrA = 4'd9;
    b1.AddrB = 4'd6;
    step();
    b1.Clear_InHigh = 1'b1;
    step();
    b1.Clear_InHigh = 1'b0;
    repeat (4) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    b1.Write_InHigh = 1'b1;
    b1.WriteAddr = 4'd6;
    b1.DataBUS_In = 32'h66;
    #3;
    chk("rstclr_busy", {31'b0, b1.Busy_OutHigh}, 32'h0);
    chk("rstclr_r9", oa1, INIT);
    chk("rstclr_r6", ob2, INIT);
    step();
    b1.Write_InHigh = 1'b0;
    #3;
    chk("rstclr_w6", ob1, 32'h66);
    chk("rstclr_w6b", ob2, 32'h66);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
